// File: rtl/motor_sequencer.sv
// Velocity-profile sequencer: ramps a signed command to a latched target, dwells,
// ramps back to zero, optionally repeats in reverse, and faults on stall during the hold.
module motor_sequencer #(
    parameter int          TICK_DIV    = 1000,
    parameter logic [7:0]  STEP        = 8'd4,
    parameter logic [15:0] DWELL_TICKS = 16'd500,
    parameter logic [7:0]  STALL_RPM   = 8'd2,
    parameter logic [15:0] STALL_TICKS = 16'd50
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              start,
    input  logic              stop,
    input  logic signed [7:0] target,
    input  logic              reverse,
    input  logic [7:0]        rpm,
    output logic signed [7:0] velocity,
    output logic [2:0]        state,
    output logic              busy,
    output logic              fault,
    output logic              done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCEL = 3'd1,
        S_DWELL = 3'd2,
        S_DECEL = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic signed [7:0] velocity_reg, velocity_next;
    logic signed [7:0] tgt_reg, tgt_next;
    logic              rev_reg, rev_next;
    logic              leg_reg, leg_next;
    logic              stopped_reg, stopped_next;
    logic [PW-1:0]     presc_reg, presc_next;
    logic [15:0]       dwell_cnt_reg, dwell_cnt_next;
    logic [15:0]       stall_cnt_reg, stall_cnt_next;
    logic              busy_reg, busy_next;
    logic              fault_reg, fault_next;
    logic              done_reg, done_next;

    logic              tick;
    logic              stall_en;
    logic              stall_low;
    logic              stall_hit;
    logic              dwell_end;
    logic              accept;
    logic              leg_change;
    logic signed [7:0] vel_to_tgt;
    logic signed [7:0] vel_to_zero;

    // Move cur toward goal by STEP without overshooting goal. The 9-bit difference
    // keeps the span between any two 8-bit values representable.
    function automatic logic signed [7:0] step_toward(input logic signed [7:0] cur,
                                                      input logic signed [7:0] goal);
        logic signed [8:0] diff;
        logic signed [8:0] step_w;
        diff   = 9'(goal) - 9'(cur);
        step_w = $signed({1'b0, STEP});
        if (diff > 9'sd0)
            return (diff <= step_w) ? goal : cur + $signed(STEP);
        else if (diff < 9'sd0)
            return (-diff <= step_w) ? goal : cur - $signed(STEP);
        else
            return cur;
    endfunction

    assign tick        = (state_reg != S_IDLE) && (presc_reg == PW'(TICK_DIV - 1));
    assign vel_to_tgt  = step_toward(velocity_reg, tgt_reg);
    assign vel_to_zero = step_toward(velocity_reg, 8'sd0);
    assign stall_en    = (tgt_reg != 8'sd0);
    assign stall_low   = (rpm < STALL_RPM);
    assign stall_hit   = tick && stall_en && stall_low && ((stall_cnt_reg + 16'd1) == STALL_TICKS);
    assign dwell_end   = tick && ((dwell_cnt_reg + 16'd1) == DWELL_TICKS);

    // State register
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && !stop)
                    state_next = S_ACCEL;
            end
            S_ACCEL: begin
                if (stop)
                    state_next = S_DECEL;
                else if (tick && (vel_to_tgt == tgt_reg))
                    state_next = S_DWELL;
            end
            S_DWELL: begin
                // A stall wins over a simultaneous stop or dwell expiry.
                if (stall_hit)
                    state_next = S_FAULT;
                else if (stop || dwell_end)
                    state_next = S_DECEL;
            end
            S_DECEL: begin
                if (tick && (vel_to_zero == 8'sd0)) begin
                    if (rev_reg && !leg_reg && !(stopped_reg || stop))
                        state_next = S_ACCEL;
                    else
                        state_next = S_IDLE;
                end
            end
            S_FAULT: begin
                if (stop)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept     = (state_reg == S_IDLE) && (state_next == S_ACCEL);
    assign leg_change = (state_reg == S_DECEL) && (state_next == S_ACCEL);

    // Output and datapath next values
    always_comb begin
        velocity_next  = velocity_reg;
        tgt_next       = tgt_reg;
        rev_next       = rev_reg;
        leg_next       = leg_reg;
        stopped_next   = stopped_reg;
        presc_next     = presc_reg;
        dwell_cnt_next = dwell_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        busy_next      = (state_next != S_IDLE);
        fault_next     = (state_next == S_FAULT);
        done_next      = (state_reg == S_DECEL) && (state_next == S_IDLE);

        if (state_reg == S_IDLE || leg_change)
            presc_next = '0;
        else if (presc_reg == PW'(TICK_DIV - 1))
            presc_next = '0;
        else
            presc_next = presc_reg + PW'(1);

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    tgt_next     = (target == -8'sd128) ? -8'sd127 : target;
                    rev_next     = reverse;
                    leg_next     = 1'b0;
                    stopped_next = 1'b0;
                end
            end
            S_ACCEL: begin
                if (stop)
                    stopped_next = 1'b1;
                else if (tick)
                    velocity_next = vel_to_tgt;
            end
            S_DWELL: begin
                if (stall_hit)
                    velocity_next = 8'sd0;
                else if (stop)
                    stopped_next = 1'b1;
            end
            S_DECEL: begin
                if (stop)
                    stopped_next = 1'b1;
                if (tick)
                    velocity_next = vel_to_zero;
                if (leg_change) begin
                    leg_next = 1'b1;
                    tgt_next = -tgt_reg;
                end
            end
            S_FAULT: velocity_next = 8'sd0;
            default: velocity_next = 8'sd0;
        endcase

        if (state_next != state_reg) begin
            dwell_cnt_next = '0;
            stall_cnt_next = '0;
        end else if (state_reg == S_DWELL && tick) begin
            dwell_cnt_next = dwell_cnt_reg + 16'd1;
            if (stall_en)
                stall_cnt_next = stall_low ? stall_cnt_reg + 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            velocity_reg  <= 8'sd0;
            tgt_reg       <= 8'sd0;
            rev_reg       <= 1'b0;
            leg_reg       <= 1'b0;
            stopped_reg   <= 1'b0;
            presc_reg     <= '0;
            dwell_cnt_reg <= '0;
            stall_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            velocity_reg  <= velocity_next;
            tgt_reg       <= tgt_next;
            rev_reg       <= rev_next;
            leg_reg       <= leg_next;
            stopped_reg   <= stopped_next;
            presc_reg     <= presc_next;
            dwell_cnt_reg <= dwell_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            busy_reg      <= busy_next;
            fault_reg     <= fault_next;
            done_reg      <= done_next;
        end
    end

    assign velocity = velocity_reg;
    assign state    = state_reg;
    assign busy     = busy_reg;
    assign fault    = fault_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer: edge-numbered stimulus with hand-computed expectations.
module tb_motor_sequencer;

    logic              cclk;
    logic              rstb;
    logic              start;
    logic              stop;
    logic signed [7:0] target;
    logic              reverse;
    logic [7:0]        rpm;
    logic signed [7:0] velocity;
    logic [2:0]        state;
    logic              busy;
    logic              fault;
    logic              done;

    logic signed [7:0] sat_velocity;
    logic [2:0]        sat_state;
    logic              sat_busy;
    logic              sat_fault;
    logic              sat_done;

    int checks = 0;
    int errors = 0;
    int edge_num = 0;

    motor_sequencer #(
        .TICK_DIV(4), .STEP(8'd10), .DWELL_TICKS(16'd3),
        .STALL_RPM(8'd5), .STALL_TICKS(16'd2)
    ) dut (
        .cclk(cclk), .rstb(rstb), .start(start), .stop(stop), .target(target),
        .reverse(reverse), .rpm(rpm), .velocity(velocity), .state(state),
        .busy(busy), .fault(fault), .done(done)
    );

    motor_sequencer #(
        .TICK_DIV(4), .STEP(8'd127), .DWELL_TICKS(16'd3),
        .STALL_RPM(8'd5), .STALL_TICKS(16'd2)
    ) dut_sat (
        .cclk(cclk), .rstb(rstb), .start(start), .stop(stop), .target(target),
        .reverse(reverse), .rpm(rpm), .velocity(sat_velocity), .state(sat_state),
        .busy(sat_busy), .fault(sat_fault), .done(sat_done)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("edge %0d %s = %0d", edge_num, tag, obs);
        else begin
            errors++;
            $error("FAIL %s @edge %0d observed=%0d expected=%0d", tag, edge_num, obs, exp);
        end
    endtask

    task automatic go_edge(input int n);
        while (edge_num < n) begin
            @(posedge cclk);
            edge_num++;
        end
        #1;
    endtask

    task automatic begin_move(input logic signed [7:0] t, input logic r);
        @(negedge cclk);
        start   = 1'b1;
        target  = t;
        reverse = r;
        @(posedge cclk);
        edge_num = 0;
        #1;
        start = 1'b0;
    endtask

    task automatic reset_pulse();
        rstb = 1'b0;
        #2;
        @(negedge cclk);
        rstb = 1'b1;
    endtask

    int done_cnt;

    initial begin
        rstb = 1'b0; start = 1'b0; stop = 1'b0;
        target = 8'sd0; reverse = 1'b0; rpm = 8'd20;

        #12;
        check("rst_velocity", velocity, 0);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_done", done, 0);
        @(negedge cclk);
        rstb = 1'b1;

        // Basic move, target 25, no reverse
        begin_move(8'sd25, 1'b0);
        check("basic_accel_state", state, 1);
        check("basic_busy", busy, 1);
        go_edge(3);  check("basic_vel3", velocity, 0);
        go_edge(4);  check("basic_vel4", velocity, 10);
        go_edge(8);  check("basic_vel8", velocity, 20);
        go_edge(12); check("basic_vel12", velocity, 25);
        check("basic_dwell_state", state, 2);
        go_edge(23); check("basic_dwell23", state, 2);
        go_edge(24); check("basic_decel_state", state, 3);
        go_edge(28); check("basic_vel28", velocity, 15);
        go_edge(32); check("basic_vel32", velocity, 5);
        go_edge(35); check("basic_done35", done, 0);
        go_edge(36); check("basic_vel36", velocity, 0);
        check("basic_idle", state, 0);
        check("basic_done36", done, 1);
        check("basic_busy36", busy, 0);
        go_edge(37); check("basic_done37", done, 0);

        // Reverse leg
        go_edge(40);
        begin_move(8'sd25, 1'b1);
        go_edge(36); check("rev_state36", state, 1);
        check("rev_vel36", velocity, 0);
        check("rev_done36", done, 0);
        go_edge(40); check("rev_vel40", velocity, -10);
        go_edge(44); check("rev_vel44", velocity, -20);
        go_edge(48); check("rev_vel48", velocity, -25);
        check("rev_dwell48", state, 2);
        go_edge(60); check("rev_decel60", state, 3);
        go_edge(64); check("rev_vel64", velocity, -15);
        done_cnt = 0;
        for (int e = 65; e <= 71; e++) begin
            go_edge(e);
            if (done) done_cnt++;
        end
        check("rev_no_early_done", done_cnt, 0);
        go_edge(72); check("rev_idle72", state, 0);
        check("rev_done72", done, 1);
        go_edge(73); check("rev_done73", done, 0);

        // Stall during dwell
        go_edge(76);
        begin_move(8'sd25, 1'b0);
        go_edge(12); rpm = 8'd0;
        go_edge(19); check("stall_dwell19", state, 2);
        check("stall_vel19", velocity, 25);
        go_edge(20); check("stall_fault_state", state, 4);
        check("stall_vel20", velocity, 0);
        check("stall_fault_flag", fault, 1);
        go_edge(24); start = 1'b1;
        go_edge(25); start = 1'b0;
        check("stall_start_ignored", state, 4);
        go_edge(29); stop = 1'b1;
        go_edge(30); stop = 1'b0;
        check("stall_cleared", state, 0);
        check("stall_fault_clr", fault, 0);
        check("stall_no_done30", done, 0);
        go_edge(31); check("stall_no_done31", done, 0);
        rpm = 8'd20;

        // Stop in ACCEL suppresses the reverse leg
        go_edge(34);
        begin_move(8'sd25, 1'b1);
        go_edge(4);  check("stop_vel4", velocity, 10);
        go_edge(5);  stop = 1'b1;
        go_edge(6);  stop = 1'b0;
        check("stop_decel6", state, 3);
        check("stop_vel6", velocity, 10);
        go_edge(8);  check("stop_vel8", velocity, 0);
        check("stop_idle8", state, 0);
        check("stop_done8", done, 1);
        go_edge(12); check("stop_no_rev", state, 0);

        // Saturation of -128 with a large step
        reset_pulse();
        begin_move(-8'sd128, 1'b0);
        go_edge(4);  check("sat_vel4", sat_velocity, -127);
        check("sat_dwell4", sat_state, 2);
        check("sat_small_step", velocity, -10);

        // start and stop together in IDLE
        reset_pulse();
        @(negedge cclk);
        start = 1'b1; stop = 1'b1; target = 8'sd25;
        @(posedge cclk); #1;
        start = 1'b0; stop = 1'b0;
        check("collide_state", state, 0);
        check("collide_busy", busy, 0);
        @(posedge cclk); #1;
        check("collide_state2", state, 0);

        // Asynchronous reset mid-dwell
        begin_move(8'sd25, 1'b0);
        go_edge(14); check("areset_pre_state", state, 2);
        check("areset_pre_vel", velocity, 25);
        rstb = 1'b0;
        #2;
        check("areset_vel", velocity, 0);
        check("areset_state", state, 0);
        check("areset_busy", busy, 0);
        @(negedge cclk);
        rstb = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Velocity-profile sequencer that sits between the command source and a `motor_driver` instance. On a start pulse it ramps the signed velocity command toward a latched target at a fixed slew rate. It holds the target for a dwell period, ramps back to zero and, optionally, repeats the move in the opposite direction. During the hold it monitors RPM feedback from `encoder_to_rpm` and drops the command to zero and enters a fault state on stall. One instance drives one motor channel.

## Interface
- `TICK_DIV`, 1000: clock cycles per ramp/dwell tick (≥2).
- `STEP`, 8'd4: velocity magnitude change per tick during ramps (1..127).
- `DWELL_TICKS`, 16'd500: ticks spent holding the target.
- `STALL_RPM`, 8'd2: RPM threshold; feedback strictly below it counts as stalled.
- `STALL_TICKS`, 16'd50: consecutive stalled ticks in DWELL that trigger FAULT.
- `cclk` input 1: system clock; all logic on the rising edge.
- `rstb` input 1: reset, asynchronous and active-low.
- `start` input 1: single-cycle request to begin a move.
- `stop` input 1: single-cycle request to end a move gracefully, or to clear FAULT.
- `target` input 8: signed two's-complement velocity; sampled on start acceptance.
- `reverse` input 1: sampled with `target`; when 1, a second leg runs at −target.
- `rpm` input 8: unsigned speed feedback.
- `velocity` output 8: signed command to `motor_driver`; registered.
- `state` output 3: IDLE=0, ACCEL=1, DWELL=2, DECEL=3, FAULT=4.
- `busy` output 1: state ≠ IDLE.
- `fault` output 1: state = FAULT.
- `done` output 1: one-cycle pulse on normal return to IDLE.

## Operation
- Reset values: `velocity`=0, `state`=IDLE, `busy`=0, `fault`=0, `done`=0. Prescaler, dwell counter, stall counter and leg flag are 0.
- Tick: the prescaler counts 0..TICK_DIV−1 and asserts internal `tick` at TICK_DIV−1. It is cleared on start acceptance and on every leg change.
- IDLE: `start`=1 with `stop`=0 latches `tgt`, `rev` and leg=0, then moves to ACCEL. `start` and `stop` in the same cycle means the start is ignored.
- Target saturation: a latched `target` of −128 is treated as −127. The second leg uses −tgt.
- ACCEL: on each tick, `velocity` moves toward `tgt` by STEP and saturates exactly at `tgt` (no overshoot). On the tick edge where `velocity`=`tgt`, the state moves to DWELL. If `tgt`=0, DWELL is entered on the first tick.
- DWELL: counts ticks. After DWELL_TICKS ticks the state moves to DECEL.
- Stall monitor (DWELL only, disabled if `tgt`=0):
  - On each tick, `rpm`<STALL_RPM increments the stall counter; otherwise the counter clears.
  - When the counter reaches STALL_TICKS, the state moves to FAULT and `velocity` is forced to 0 on that same edge.
- DECEL: on each tick, `velocity` moves toward 0 by STEP, saturating at 0. On the edge reaching 0:
  - If `rev`=1, leg=0 and no stop was seen, the block sets leg=1, sets `tgt` to −tgt and moves to ACCEL.
  - Otherwise it moves to IDLE and pulses `done`.
- `stop` during a move:
  - In ACCEL or DWELL: move to DECEL on the next edge and set the stopped flag, which suppresses the reverse leg.
  - In DECEL: only sets the stopped flag.
  - In IDLE: no effect.
- FAULT: `velocity` is held at 0. `stop` returns the state to IDLE with no `done` pulse. `start` is ignored.
- Counter clearing: dwell and stall counters clear on every state change.
- Reset mid-move: `velocity` goes to 0 asynchronously and all state is lost.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Start latency:
  - If start is sampled at edge N, `state`=ACCEL from edge N.
  - The first velocity step appears at edge N+TICK_DIV.
  - Later steps follow every TICK_DIV cycles.
- State transitions and `velocity` updates triggered by a tick occur on the same edge.
- `stop` is acted on at the edge where it is sampled. Velocity steps in DECEL keep the existing prescaler phase.
- `done` is high for exactly one cycle, the cycle after the edge that enters IDLE.

## Test plan
Common parameters: TICK_DIV=4, STEP=10, DWELL_TICKS=3, STALL_TICKS=2, STALL_RPM=5. `rpm`=20 unless stated.
- Basic move: start at edge 0 with target=25 and reverse=0.
  - `velocity` = 10@4, 20@8, 25@12 (DWELL).
  - DECEL entered @24; `velocity` = 15@28, 5@32, 0@36.
  - IDLE @36, `done` pulse follows.
- Reverse: same as basic move with reverse=1.
  - After reaching 0 @36, ACCEL restarts: −10@40, −20@44, −25@48.
  - The move ends in IDLE with a single `done` pulse.
- Stall: target=25, `rpm` forced to 0 from edge 12.
  - FAULT and `velocity`=0 @20.
  - `stop` @30 → IDLE, `done` stays 0.
- Stop in ACCEL: stop at edge 6 with reverse=1.
  - DECEL @6, `velocity` 10→0 @8.
  - IDLE with no reverse leg.
- Saturation and collision:
  - target=−128, STEP=127 → `velocity`=−127 after the first tick.
  - `start` and `stop` both high in IDLE → state stays IDLE.
- Async reset: `rstb` low mid-DWELL → `velocity`=0 and `state`=0 immediately, without waiting for a clock edge.
